// File: rtl/fsm_cap_pkg.sv
// Shared types, default parameters and the MISR step function for the
// FSM output capture block (fsm_out_capture, fsm_cap_fifo).
package fsm_cap_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } cap_state_t;

  localparam int          OUT_W_DEF     = 18;
  localparam int          DEPTH_DEF     = 16;
  localparam logic [17:0] MISR_POLY_DEF = 18'h00081;
  localparam logic [17:0] MISR_SEED_DEF = 18'h00000;

  // Widest signature the step function handles; callers zero-extend into it.
  localparam int MISR_MAX_W = 32;

  // One MISR step on a w-bit signature: shift left, fold the bit shifted out
  // back through the tap polynomial, then xor in the captured word.
  function automatic logic [MISR_MAX_W-1:0] misr_next(
    input logic [MISR_MAX_W-1:0] sig,
    input logic [MISR_MAX_W-1:0] y,
    input logic [MISR_MAX_W-1:0] poly,
    input int                    w
  );
    logic [MISR_MAX_W-1:0] mask;
    logic [MISR_MAX_W-1:0] fb;
    mask = (w >= MISR_MAX_W) ? '1 : ((32'd1 << w) - 32'd1);
    fb   = (((sig >> (w - 1)) & 32'd1) != 32'd0) ? poly : '0;
    return ((sig << 1) ^ fb ^ y) & mask;
  endfunction

endpackage

// File: rtl/fsm_cap_fifo.sv
// First-word-fall-through FIFO for captured output words.
// The head word is presented combinationally; an empty FIFO shows zero so no
// stale storage contents ever reach the reader. A push while full is accepted
// only when a pop happens in the same cycle.
module fsm_cap_fifo #(
  parameter int W     = 18,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr,
  input  logic                     push,
  input  logic [W-1:0]             wdata,
  input  logic                     pop,
  output logic [W-1:0]             rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = empty ? '0 : mem[rd_ptr];

  // Pointer and occupancy tracking; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (!do_push && do_pop) count <= count - 1'b1;
    end
  end

  // Storage array; not reset, validity is tracked by count alone.
  always_ff @(posedge clk) begin
    if (do_push && !clr && !rst) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/fsm_out_capture.sv
// Observer for small-FSM output vectors: captures y_in every cycle while
// enabled into an FWFT FIFO and folds each captured word into a MISR.
// Optional build macro: FSM_OUT_ZERO_SKIP_EN -- when defined, all-zero words
// still update the MISR but are not pushed (and so never overflow).
//
// state   | meaning
// --------+----------------------------------------------------------
// ST_IDLE | not capturing; cap_en moves to ST_RUN on the next edge
// ST_RUN  | push y_in and update MISR each edge; cap_en low -> ST_IDLE
// ST_HALT | a word was dropped on a full FIFO; MISR frozen, drain only,
//         | left only through clr or rst
module fsm_out_capture
  import fsm_cap_pkg::*;
#(
  parameter int               OUT_W     = OUT_W_DEF,
  parameter int               DEPTH     = DEPTH_DEF,
  parameter logic [OUT_W-1:0] MISR_POLY = OUT_W'(MISR_POLY_DEF),
  parameter logic [OUT_W-1:0] MISR_SEED = OUT_W'(MISR_SEED_DEF)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [OUT_W-1:0]       y_in,
  input  logic                   cap_en,
  input  logic                   clr,
  input  logic                   rd_ready,
  output logic                   rd_valid,
  output logic [OUT_W-1:0]       rd_data,
  output logic [$clog2(DEPTH):0] fifo_count,
  output logic                   overflow,
  output logic [OUT_W-1:0]       sig,
  output logic [1:0]             state_o
);

  cap_state_t       state;
  logic             full;
  logic             empty;
  logic             run_cap;
  logic             zero_word;
  logic             want_push;
  logic             pop;
  logic             drop;
  logic             push;
  logic             misr_upd;
  logic [OUT_W-1:0] sig_step;

  assign rd_valid = !empty;
  assign state_o  = state;

`ifdef FSM_OUT_ZERO_SKIP_EN
  assign zero_word = (y_in == '0);
`else
  assign zero_word = 1'b0;
`endif

  // A capture cycle is RUN with cap_en still high; the exit cycle captures nothing.
  assign run_cap   = (state == ST_RUN) && cap_en;
  assign want_push = run_cap && !zero_word;
  assign pop       = rd_valid && rd_ready;
  assign drop      = want_push && full && !pop;
  assign push      = want_push && !drop;
  assign misr_upd  = run_cap && !drop;
  assign sig_step  = OUT_W'(misr_next(32'(sig), 32'(y_in), 32'(MISR_POLY), OUT_W));

  fsm_cap_fifo #(
    .W     (OUT_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .clr   (clr),
    .push  (push),
    .wdata (y_in),
    .pop   (pop),
    .rdata (rd_data),
    .full  (full),
    .empty (empty),
    .count (fifo_count)
  );

  // Control FSM with the sticky overflow flag and MISR signature.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      overflow <= 1'b0;
      sig      <= MISR_SEED;
    end else if (clr) begin
      state    <= ST_IDLE;
      overflow <= 1'b0;
      sig      <= MISR_SEED;
    end else begin
      if (misr_upd) sig <= sig_step;
      if (drop)     overflow <= 1'b1;
      case (state)
        ST_IDLE: if (cap_en) state <= ST_RUN;
        ST_RUN: begin
          if (!cap_en)  state <= ST_IDLE;
          else if (drop) state <= ST_HALT;
        end
        ST_HALT: state <= ST_HALT;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fsm_out_capture.sv
// Directed bench for fsm_out_capture with default parameters
// (OUT_W=18, DEPTH=16, MISR_POLY=18'h00081, MISR_SEED=0).
module tb_fsm_out_capture;

  logic        clk = 1'b0;
  logic        rst;
  logic [17:0] y_in;
  logic        cap_en;
  logic        clr;
  logic        rd_ready;
  logic        rd_valid;
  logic [17:0] rd_data;
  logic [4:0]  fifo_count;
  logic        overflow;
  logic [17:0] sig;
  logic [1:0]  state_o;

  int n_vec = 0;
  int n_bad = 0;

  fsm_out_capture dut (
    .clk        (clk),
    .rst        (rst),
    .y_in       (y_in),
    .cap_en     (cap_en),
    .clr        (clr),
    .rd_ready   (rd_ready),
    .rd_valid   (rd_valid),
    .rd_data    (rd_data),
    .fifo_count (fifo_count),
    .overflow   (overflow),
    .sig        (sig),
    .state_o    (state_o)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [17:0] ref_misr(input logic [17:0] s, input logic [17:0] y);
    logic [17:0] r;
    r = {s[16:0], 1'b0} ^ y;
    if (s[17]) r = r ^ 18'h00081;
    return r;
  endfunction

  logic [17:0] exp_sig;
  logic [17:0] sig_hold;

  initial begin
    rst = 1'b1; y_in = '0; cap_en = 1'b0; clr = 1'b0; rd_ready = 1'b0;
    step();
    step();
    rst = 1'b0;

    // reset state
    check_val("rst_valid", 32'(rd_valid), 0);
    check_val("rst_data", 32'(rd_data), 0);
    check_val("rst_count", 32'(fifo_count), 0);
    check_val("rst_ovf", 32'(overflow), 0);
    check_val("rst_sig", 32'(sig), 0);
    check_val("rst_state", 32'(state_o), 0);

    // basic capture of 1, 2
    cap_en = 1'b1; y_in = 18'h00001;
    step();
    check_val("lat_state", 32'(state_o), 1);
    check_val("lat_count", 32'(fifo_count), 0);
    check_val("lat_sig", 32'(sig), 0);
    step();
    check_val("cap1_count", 32'(fifo_count), 1);
    check_val("cap1_sig", 32'(sig), 32'h00001);
    check_val("cap1_valid", 32'(rd_valid), 1);
    check_val("cap1_data", 32'(rd_data), 32'h00001);
    y_in = 18'h00002;
    step();
    check_val("cap2_count", 32'(fifo_count), 2);
    check_val("cap2_sig", 32'(sig), 32'h00000);
    check_val("cap2_head", 32'(rd_data), 32'h00001);
    cap_en = 1'b0; y_in = 18'h00123;
    step();
    check_val("exit_state", 32'(state_o), 0);
    check_val("exit_count", 32'(fifo_count), 2);
    check_val("exit_sig", 32'(sig), 0);
    rd_ready = 1'b1;
    step();
    check_val("pop1_data", 32'(rd_data), 32'h00002);
    check_val("pop1_count", 32'(fifo_count), 1);
    step();
    check_val("pop2_count", 32'(fifo_count), 0);
    check_val("pop2_valid", 32'(rd_valid), 0);
    check_val("pop2_data", 32'(rd_data), 0);
    step();
    check_val("pop_empty_count", 32'(fifo_count), 0);
    rd_ready = 1'b0;

    // overflow into HALT
    clr = 1'b1;
    step();
    clr = 1'b0; cap_en = 1'b1;
    step();
    exp_sig = '0;
    for (int i = 0; i < 17; i++) begin
      y_in = 18'(i + 1);
      if (i < 16) exp_sig = ref_misr(exp_sig, 18'(i + 1));
      step();
    end
    check_val("ovf_count", 32'(fifo_count), 16);
    check_val("ovf_flag", 32'(overflow), 1);
    check_val("ovf_state", 32'(state_o), 2);
    check_val("ovf_sig", 32'(sig), 32'(exp_sig));
    for (int i = 0; i < 3; i++) begin
      y_in = 18'h3ffff;
      cap_en = (i != 1);
      step();
      check_val("halt_sig", 32'(sig), 32'(exp_sig));
      check_val("halt_count", 32'(fifo_count), 16);
      check_val("halt_state", 32'(state_o), 2);
    end
    check_val("halt_head", 32'(rd_data), 1);
    rd_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      check_val("halt_drain", 32'(rd_data), 32'(i + 2));
    end
    check_val("halt_drain_count", 32'(fifo_count), 12);
    check_val("halt_drain_state", 32'(state_o), 2);
    clr = 1'b1;
    step();
    clr = 1'b0; rd_ready = 1'b0; cap_en = 1'b0;
    check_val("clr_state", 32'(state_o), 0);
    check_val("clr_count", 32'(fifo_count), 0);
    check_val("clr_ovf", 32'(overflow), 0);
    check_val("clr_valid", 32'(rd_valid), 0);
    check_val("clr_sig", 32'(sig), 0);

    // full FIFO with concurrent drain
    cap_en = 1'b1;
    step();
    for (int i = 0; i < 16; i++) begin
      y_in = 18'(32'h100 + i);
      step();
    end
    check_val("full_count", 32'(fifo_count), 16);
    rd_ready = 1'b1;
    for (int j = 0; j < 20; j++) begin
      y_in = 18'(32'h100 + 16 + j);
      step();
      check_val("pp_count", 32'(fifo_count), 16);
      check_val("pp_ovf", 32'(overflow), 0);
      check_val("pp_data", 32'(rd_data), 32'h100 + j + 1);
    end
    check_val("pp_state", 32'(state_o), 1);
    rd_ready = 1'b0; cap_en = 1'b0;
    clr = 1'b1;
    step();
    clr = 1'b0;

    // asynchronous reset mid-capture
    cap_en = 1'b1;
    step();
    for (int i = 0; i < 5; i++) begin
      y_in = 18'(32'h2a0 + i);
      step();
    end
    check_val("pre_rst_count", 32'(fifo_count), 5);
    sig_hold = sig;
    check_val("pre_rst_sig_nz", 32'(sig_hold != 18'h0), 1);
    #2;
    rst = 1'b1;
    #1;
    check_val("arst_valid", 32'(rd_valid), 0);
    check_val("arst_count", 32'(fifo_count), 0);
    check_val("arst_sig", 32'(sig), 0);
    check_val("arst_data", 32'(rd_data), 0);
    check_val("arst_state", 32'(state_o), 0);
    #1;
    rst = 1'b0;

    // zero words
    cap_en = 1'b1; y_in = '0;
    step();
    step();
    step();
    y_in = 18'h00010;
    step();
`ifdef FSM_OUT_ZERO_SKIP_EN
    check_val("zs_count", 32'(fifo_count), 1);
    check_val("zs_data", 32'(rd_data), 32'h00010);
`else
    check_val("zero_count", 32'(fifo_count), 3);
    check_val("zero_data", 32'(rd_data), 0);
`endif
    check_val("zero_sig", 32'(sig), 32'h00010);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/fsm_out_capture.md
Name: fsm_out_capture

Overview:
- Downstream observer for the small-FSM benchmarks: captures the 18-bit registered-free Mealy output vector (y1..y18) every cycle while enabled.
- Buffers captured words in a first-word-fall-through (FWFT) FIFO drained by a valid/ready reader.
- Compacts every captured word into a MISR signature, so locked and unlocked FSM instances can be compared by trace or by signature.
- Samples on posedge clk, half a cycle after the FSM's negedge state update, so y_in is settled.

Parameters:
- OUT_W, 18: width of observed output vector.
- DEPTH, 16: FIFO entries; power of two, >= 2.
- MISR_POLY, 18'h00081: feedback taps (x^18+x^7+1), OUT_W bits.
- MISR_SEED, 0: signature value after reset or clear.

Ports:
- clk  input  1  clock; all sampling on rising edge.
- rst  input  1  asynchronous, active-high reset.
- y_in  input  OUT_W  FSM output vector; y_in[0]=y1.
- cap_en  input  1  capture enable (level).
- clr  input  1  synchronous clear; highest priority after rst.
- rd_ready  input  1  reader accepts head word.
- rd_valid  output  1  FIFO non-empty.
- rd_data  output  OUT_W  FIFO head word (FWFT).
- fifo_count  output  $clog2(DEPTH)+1  occupancy, 0..DEPTH.
- overflow  output  1  sticky: a capture was dropped.
- sig  output  OUT_W  current MISR signature.
- state_o  output  2  encoded control state (IDLE=0, RUN=1, HALT=2).

Behaviour:
- Reset is asynchronous, active-high on rst; clock is clk. Reset values: state IDLE, FIFO empty, rd_valid 0, rd_data 0, fifo_count 0, overflow 0, sig MISR_SEED.
- clr (sync) produces the same values as reset at the next edge. A pop and push in the clr cycle are discarded.
- State IDLE:
  - no capture;
  - cap_en=1 -> RUN at the next edge (first capture occurs at that edge's following edge, i.e. one cycle latency from cap_en rise).
- State RUN, every edge:
  - push y_in;
  - sig <= {sig[OUT_W-2:0],1'b0} ^ (sig[OUT_W-1] ? MISR_POLY : 0) ^ y_in.
  - cap_en=0 sampled -> IDLE; no capture in that cycle.
- Push while full:
  - with a pop the same cycle: both occur, count unchanged, no overflow;
  - with no pop: word dropped, overflow<=1, MISR not updated for that word, state -> HALT.
- State HALT:
  - no capture, MISR frozen;
  - draining continues;
  - leaves only via clr or rst (to IDLE).
- Pop: transfer when rd_valid && rd_ready at an edge; rd_data shows the new head after that edge. Pop while empty is ignored.
- Latency: a word pushed at edge N is visible on rd_data / rd_valid immediately after edge N if the FIFO was empty.
- fifo_count changes by +1, -1 or 0 per edge.
- Pointers wrap modulo DEPTH; the full/empty distinction uses the extra count bit.
- rst asserted mid-drain or mid-capture: contents are lost and no partial word is emitted.

Optional Feature:
- Macro: FSM_OUT_ZERO_SKIP_EN.
- Defined: in RUN, an all-zero y_in (FSM self-loop with no asserted output) is not pushed. The MISR still updates with it, and such a word can never cause overflow.
- Undefined: every RUN cycle pushes, including zero words.

Decomposition:
- Package fsm_cap_pkg holds:
  - state enum (IDLE, RUN, HALT);
  - default OUT_W, DEPTH, MISR_POLY, MISR_SEED constants;
  - the MISR next-state function.
- Sub-module fsm_cap_fifo: parameterised FWFT FIFO with push/pop/full/empty/count. The top instantiates it and holds the control FSM and MISR.

Test Plan:
- Reset then cap_en=1; y_in=18'h00001 then 18'h00002 (SEED=0) -> FIFO holds 1,2; sig goes 18'h00001 then 18'h00000; fifo_count=2.
- rd_ready=0; capture 17 words with DEPTH=16 -> fifo_count=16, overflow=1, state_o=2; further y_in has no effect on sig or count.
- FIFO full with rd_ready=1 and capture continuing -> count stays 16 and overflow stays 0 across 20 cycles; rd_data is in capture order.
- rst pulse mid-capture at count=5 -> rd_valid=0, fifo_count=0, sig=MISR_SEED asynchronously, before the next clk edge.
- clr in HALT with rd_ready=1 -> next edge: state IDLE, count 0, overflow 0; the popped word is not delivered.
- With FSM_OUT_ZERO_SKIP_EN: y_in sequence 0,0,18'h00010 -> fifo_count=1, rd_data=18'h00010, sig=18'h00010.
